// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO stream reader slice.
// Contents: default data width, buffer occupancy width, fetch FSM state encoding.
package fifo_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned OCC_WIDTH          = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } state_t;

endpackage

// File: rtl/stream_skid_buf2.sv
// Two-entry in-order output buffer (head + skid) with push/pop/clear.
// Ports:
//   clk, reset      clock, async active-low reset
//   push, push_data write one word into the first free entry (after any pop)
//   pop             remove the head word; skid moves to head
//   clear           drop all buffered words (wins over push/pop)
//   occ             number of buffered words (0..2)
//   head_data       current head word
module stream_skid_buf2
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  input  logic                  clear,
  output logic [OCC_WIDTH-1:0]  occ,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [DATA_WIDTH-1:0] skid_data;
  logic                  pop_ok;
  logic [OCC_WIDTH-1:0]  occ_after_pop;

  // A pop on an empty buffer is ignored so occ can never underflow.
  assign pop_ok        = pop & (occ != OCC_WIDTH'(0));
  assign occ_after_pop = occ - OCC_WIDTH'(pop_ok);

  // Storage and occupancy; the push lands in the entry that is free once the pop is applied.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ       <= '0;
      head_data <= '0;
      skid_data <= '0;
    end else if (clear) begin
      occ <= '0;
    end else begin
      if (pop_ok) begin
        head_data <= skid_data;
      end
      if (push) begin
        if (occ_after_pop == OCC_WIDTH'(0)) begin
          head_data <= push_data;
        end else begin
          skid_data <= push_data;
        end
      end
      occ <= occ_after_pop + OCC_WIDTH'(push);
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO read port (one-cycle read latency) into a valid/ready stream.
// Ports:
//   clk, reset               clock, async active-low reset
//   enable                   1 = issue FIFO reads, 0 = finish delivering fetched words
//   flush                    one-cycle pulse discarding buffered and in-flight words
//   fifo_rd                  combinational read strobe to the FIFO
//   fifo_rd_data, fifo_empty FIFO read data (cycle after read) and empty flag
//   m_valid, m_data, m_ready output stream
//   busy                     fetch FSM not idle
//   xfer_count               completed stream handshakes, wraps
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  flush,
  output logic                  fifo_rd,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  xfer_count
);

  localparam int unsigned ACC_WIDTH = 3;

  state_t                 state;
  state_t                 state_next;
  logic                   inflight;
  logic [OCC_WIDTH-1:0]   occ;
  logic                   hs;
  logic                   push;
  logic [ACC_WIDTH-1:0]   committed;
  logic [ACC_WIDTH-1:0]   occ_next;

  assign m_valid = (occ != OCC_WIDTH'(0));
  assign hs      = m_valid & m_ready;
  assign busy    = (state != IDLE);

  // Words returning during a flush cycle or the FLUSH state are dropped.
  assign push = inflight & ~flush & (state != FLUSH);

  stream_skid_buf2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (fifo_rd_data),
    .pop       (hs),
    .clear     (flush),
    .occ       (occ),
    .head_data (m_data)
  );

  // State register, read-latency tracker and handshake counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      inflight   <= 1'b0;
      xfer_count <= '0;
    end else begin
      state    <= state_next;
      inflight <= fifo_rd;
      if (hs) begin
        xfer_count <= xfer_count + CNT_WIDTH'(1);
      end
    end
  end

  // Next state and read strobe.
  always_comb begin
    state_next = state;
    fifo_rd    = 1'b0;
    // Slots already spoken for once this cycle's handshake leaves.
    committed  = ACC_WIDTH'(occ) + ACC_WIDTH'(inflight) - ACC_WIDTH'(hs);
    occ_next   = flush ? '0 : (ACC_WIDTH'(occ) - ACC_WIDTH'(hs) + ACC_WIDTH'(push));

    fifo_rd = (state == RUN) & ~fifo_empty & ~flush & (committed < ACC_WIDTH'(2));

    case (state)
      IDLE: begin
        if (enable) state_next = RUN;
      end
      RUN: begin
        // A read issued in this very cycle still has to be delivered, so it keeps us out of IDLE.
        if (!enable) begin
          state_next = ((occ_next != '0) || fifo_rd) ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        if (enable) begin
          state_next = RUN;
        end else if (occ_next == '0) begin
          state_next = IDLE;
        end
      end
      FLUSH: begin
        state_next = enable ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (flush) state_next = FLUSH;
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomised self-checking bench for fifo_stream_reader with a queue-based FIFO and scoreboard.
module tb_fifo_stream_reader;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          flush;
  logic          fifo_rd;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_empty;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic          busy;
  logic [CW-1:0] xfer_count;

  fifo_stream_reader #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .flush       (flush),
    .fifo_rd     (fifo_rd),
    .fifo_rd_data(fifo_rd_data),
    .fifo_empty  (fifo_empty),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_ready     (m_ready),
    .busy        (busy),
    .xfer_count  (xfer_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // FIFO contents and words read out of it but not yet delivered downstream.
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] fetched[$];
  logic [DW-1:0] pend_data;
  bit            pend_v;
  int            exp_cnt;
  bit            prev_stall;
  bit            prev_flush;
  logic [DW-1:0] prev_data;

  int            cyc;
  bit            last_rd;
  bit            last_hs;
  bit            last_valid;
  logic [DW-1:0] last_data;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    fetched.delete();
    pend_v     = 1'b0;
    exp_cnt    = 0;
    prev_stall = 1'b0;
    prev_flush = 1'b0;
  endtask

  // One clock cycle: drive at negedge, sample 1ns later, advance the model for the coming posedge.
  task automatic step(input bit en, input bit fl, input bit rdy);
    bit hs;
    @(negedge clk);
    enable       = en;
    flush        = fl;
    m_ready      = rdy;
    fifo_rd_data = pend_v ? pend_data : DW'($urandom);
    fifo_empty   = (fifo_q.size() == 0);
    #1;
    cyc++;
    check_eq("rd_while_empty", fifo_rd & fifo_empty, 0);
    if (fl) check_eq("rd_during_flush", fifo_rd, 0);
    check_eq("xfer_count", xfer_count, exp_cnt % (1 << CW));
    if (prev_flush) begin
      check_eq("valid_after_flush", m_valid, 0);
    end else if (prev_stall) begin
      check_eq("stall_valid", m_valid, 1);
      check_eq("stall_data", m_data, prev_data);
    end
    hs = m_valid & m_ready;
    if (hs) begin
      if (fetched.size() == 0) check_eq("hs_without_word", 1, 0);
      else                     check_eq("order", m_data, fetched.pop_front());
      exp_cnt++;
    end
    if (fl) fetched.delete();
    pend_v = 1'b0;
    if (fifo_rd && fifo_q.size() > 0) begin
      pend_data = fifo_q.pop_front();
      pend_v    = 1'b1;
      fetched.push_back(pend_data);
    end
    check_eq("fetch_depth_over_3", fetched.size() > 3, 0);
    prev_stall = m_valid & ~m_ready;
    prev_data  = m_data;
    prev_flush = fl;
    last_rd    = fifo_rd;
    last_hs    = hs;
    last_valid = m_valid;
    last_data  = m_data;
  endtask

  initial begin
    int            first_rd;
    int            first_v;
    int            first_hs;
    int            last_hs_cyc;
    int            n_hs;
    int            n_rd;
    int            cnt_before;
    bit            found;
    logic [DW-1:0] exp_word;
    bit            pattern [4];

    pattern = '{1'b1, 1'b0, 1'b0, 1'b1};
    reset = 1'b0; enable = 1'b0; flush = 1'b0; m_ready = 1'b0;
    fifo_empty = 1'b1; fifo_rd_data = '0;
    model_reset();
    cyc = 0;

    #2;
    check_eq("reset_m_valid", m_valid, 0);
    check_eq("reset_m_data", m_data, 0);
    check_eq("reset_fifo_rd", fifo_rd, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_xfer_count", xfer_count, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Basic drain of four words at full rate.
    fifo_q = '{32'h11, 32'h22, 32'h33, 32'h44};
    first_rd = -1; first_v = -1; first_hs = -1; last_hs_cyc = -1; n_hs = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b1);
      if (last_rd && first_rd < 0) first_rd = cyc;
      if (last_valid && first_v < 0) first_v = cyc;
      if (last_hs) begin
        if (first_hs < 0) first_hs = cyc;
        last_hs_cyc = cyc;
        n_hs++;
      end
    end
    check_eq("first_word_latency", first_v - first_rd, 2);
    check_eq("basic_hs_count", n_hs, 4);
    check_eq("basic_back_to_back", last_hs_cyc - first_hs, 3);
    check_eq("basic_xfer_count", xfer_count, 4);
    repeat (4) step(1'b0, 1'b0, 1'b1);
    check_eq("basic_busy_idle", busy, 0);

    // Backpressure with ready pattern 1,0,0,1.
    for (int i = 0; i < 8; i++) fifo_q.push_back(DW'($urandom));
    n_hs = 0;
    for (int i = 0; i < 48; i++) begin
      step(1'b1, 1'b0, pattern[i % 4]);
      if (last_hs) n_hs++;
    end
    check_eq("bp_delivered", n_hs, 8);
    repeat (6) step(1'b0, 1'b0, 1'b1);
    check_eq("bp_busy_idle", busy, 0);
    check_eq("bp_leftover", fetched.size(), 0);

    // Enable drops the cycle after the first read: two reads issued, two words delivered.
    for (int i = 0; i < 6; i++) fifo_q.push_back(DW'($urandom));
    n_hs = 0; found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      step(1'b1, 1'b0, 1'b1);
      found = last_rd;
    end
    if (!found) check_eq("timeout_first_rd", 1, 0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 1'b1);
      if (last_hs) n_hs++;
    end
    check_eq("drop_delivered", n_hs, 2);
    check_eq("drop_fifo_left", fifo_q.size(), 4);
    check_eq("drop_busy_idle", busy, 0);

    // Flush while a read is in flight and m_ready is low.
    for (int i = 0; i < 4; i++) fifo_q.push_back(DW'($urandom));
    n_rd = 0;
    for (int i = 0; i < 8 && n_rd < 2; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (last_rd) n_rd++;
    end
    if (n_rd < 2) check_eq("timeout_flush_rd", 1, 0);
    exp_word   = fifo_q[0];
    cnt_before = exp_cnt;
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check_eq("flush_valid_low", last_valid, 0);
    check_eq("flush_count_kept", xfer_count, cnt_before % (1 << CW));
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      step(1'b1, 1'b0, 1'b1);
      found = last_hs;
    end
    if (!found) check_eq("timeout_after_flush", 1, 0);
    else        check_eq("flush_next_word", last_data, exp_word);
    repeat (8) step(1'b0, 1'b0, 1'b1);

    // Random traffic with refills, enable toggles and occasional flushes.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(1, 0) == 1) fifo_q.push_back(DW'($urandom));
      step($urandom_range(7, 0) != 0, $urandom_range(39, 0) == 0, $urandom_range(1, 0) == 1);
    end

    // Asynchronous reset between clock edges while streaming.
    for (int i = 0; i < 6; i++) fifo_q.push_back(DW'($urandom));
    repeat (5) step(1'b1, 1'b0, 1'b1);
    #2 reset = 1'b0;
    #1;
    check_eq("areset_m_valid", m_valid, 0);
    check_eq("areset_fifo_rd", fifo_rd, 0);
    check_eq("areset_busy", busy, 0);
    check_eq("areset_xfer_count", xfer_count, 0);
    model_reset();
    repeat (2) step(1'b1, 1'b0, 1'b1);
    reset = 1'b1;

    // Counter wrap: 17 words through a 4-bit counter.
    fifo_q.delete();
    for (int i = 0; i < 17; i++) fifo_q.push_back(DW'($urandom));
    n_hs = 0;
    for (int i = 0; i < 26; i++) begin
      step(1'b1, 1'b0, 1'b1);
      if (last_hs) n_hs++;
    end
    check_eq("wrap_delivered", n_hs, 17);
    check_eq("wrap_count", xfer_count, 1);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(2, 0) != 0) fifo_q.push_back(DW'($urandom));
      step($urandom_range(5, 0) != 0, $urandom_range(49, 0) == 0, $urandom_range(3, 0) != 0);
    end
    repeat (8) step(1'b0, 1'b0, 1'b1);
    check_eq("final_busy_idle", busy, 0);
    check_eq("final_leftover", fetched.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
